// File: rtl/serial_addsub_unit.sv
// Digit-serial add/subtract unit: one DIGIT-wide adder slice is reused for
// WIDTH/DIGIT cycles, then the result and flags are held until the consumer takes them.

module serial_addsub_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT{1'b0}}, cin_i};
endmodule

module serial_addsub_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cb,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (WIDTH > DIGIT) ? WIDTH - DIGIT : 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_addsub_unit: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, b_sh_q, res_q;
  logic [AW-1:0]     acc_q;
  logic [CW-1:0]     cnt_q;
  logic              carry_q, mode_q, a_msb_q, b_msb_q;
  logic              cb_q, ovf_q, zero_q;
  logic              accept, step, last;
  logic [WIDTH-1:0]  b_eff, acc_nxt;
  logic [DIGIT-1:0]  sum_w;
  logic              cout_w;

  assign b_eff = sub ? ~b : b;

  serial_addsub_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i   (a_sh_q[DIGIT-1:0]),
    .b_i   (b_sh_q[DIGIT-1:0]),
    .cin_i (carry_q),
    .sum_o (sum_w),
    .cout_o(cout_w)
  );

  // Sum digits enter at the MSB end so the LSB digit lands at bit 0 after N steps.
  if (WIDTH > DIGIT) begin : g_acc
    assign acc_nxt = {sum_w, acc_q};
  end else begin : g_noacc
    assign acc_nxt = sum_w;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid) begin
        accept  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(N-1)) begin
          last    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      res_q   <= '0;
      cb_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_sh_q  <= a;
      b_sh_q  <= b_eff;
      carry_q <= sub;
      mode_q  <= sub;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b_eff[WIDTH-1];
      cnt_q   <= '0;
    end else if (step) begin
      a_sh_q  <= a_sh_q >> DIGIT;
      b_sh_q  <= b_sh_q >> DIGIT;
      carry_q <= cout_w;
      acc_q   <= acc_nxt[WIDTH-1 -: AW];
      if (last) begin
        res_q  <= acc_nxt;
        cb_q   <= mode_q ^ cout_w;
        ovf_q  <= (a_msb_q == b_msb_q) && (acc_nxt[WIDTH-1] != a_msb_q);
        zero_q <= (acc_nxt == '0);
      end else begin
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign cb        = cb_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule
